// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake and registered results.
// One-cycle logic/arithmetic ops, iterative signed radix-2 Booth multiply and
// (when SEQ_ALU_DIV_EN is defined) iterative signed restoring divide. The
// result is delivered as {hi,lo}, 2*WIDTH bits.
//
// Configuration macro: SEQ_ALU_DIV_EN -- builds the divider datapath, the
//    DIV/FIX states and div_by_zero. Without it op 0011 completes in one
//    cycle with hi=lo=0 and div_by_zero tied to 0.
//
// Ports:
//    clk          rising-edge clock
//    reset        asynchronous, active-high reset
//    start        request, sampled only in IDLE
//    op[3:0]      operation select, captured with start
//    a, b         operands, captured with start
//    busy         high from the cycle after accept until done, inclusive
//    done         one-cycle completion pulse
//    hi, lo       result, held until the next accepted op completes
//    carry_out    carry out of bit WIDTH for add/sub, 0 otherwise
//    div_by_zero  set with done for divide by zero, cleared on next accept
module seq_alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             carry_out,
   output logic             div_by_zero
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_ROL  = 4'b1000;
   localparam logic [3:0] OP_ROR  = 4'b1001;
   localparam logic [3:0] OP_NOT  = 4'b1010;
   localparam logic [3:0] OP_XOR  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [SW-1:0]    cnt;

   // Booth working registers: accumulator is one bit wider than the operands
   // so that subtracting the most-negative multiplicand cannot overflow.
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   bacc;
   logic [WIDTH-1:0] bq;
   logic             bq_m1;
   logic [WIDTH:0]   bacc_n;
   logic [WIDTH-1:0] bq_n;
   logic             bq_m1_n;

   // One-cycle datapath
   logic [SW-1:0]    sh;
   logic [SW-1:0]    sh_neg;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;

   always_comb begin
      sh      = b[SW-1:0];
      // Complementary rotate amount; for sh=0 both halves equal a, so the OR
      // still yields a.
      sh_neg  = SW'(0) - sh;
      sum     = {1'b0, a} + {1'b0, b};
      dif     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_SUB:  begin alu_res = dif[WIDTH-1:0]; alu_c = dif[WIDTH]; end
         OP_MUL,
         OP_DIV:  alu_res = '0;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SHL:  alu_res = a << sh;
         OP_SHR:  alu_res = a >> sh;
         OP_ROL:  alu_res = (a << sh) | (a >> sh_neg);
         OP_ROR:  alu_res = (a >> sh) | (a << sh_neg);
         OP_NOT:  alu_res = ~a;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_NAND: alu_res = ~(a & b);
         default: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      endcase
   end

   // One Booth iteration: add/sub per {Q[0],q-1}, then arithmetic shift right
   // of the whole {acc,Q,q-1} register.
   always_comb begin
      logic [WIDTH:0]       m_ext;
      logic [WIDTH:0]       acc_t;
      logic [2*WIDTH+1:0]   shifted;
      m_ext = {mcand[WIDTH-1], mcand};
      case ({bq[0], bq_m1})
         2'b01:   acc_t = bacc + m_ext;
         2'b10:   acc_t = bacc - m_ext;
         default: acc_t = bacc;
      endcase
      shifted = {acc_t[WIDTH], acc_t, bq};
      bacc_n  = shifted[2*WIDTH+1:WIDTH+1];
      bq_n    = shifted[WIDTH:1];
      bq_m1_n = shifted[0];
   end

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] dr;
   logic [WIDTH-1:0] dv;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] dq_n;
   logic [WIDTH-1:0] dr_n;
   logic             dbz;

   // One restoring step on magnitudes; the partial remainder is widened by a
   // bit because it can reach 2*divisor before the trial subtract.
   always_comb begin
      logic [WIDTH:0] rem_sh;
      logic [WIDTH:0] trial;
      rem_sh = {dr, dq[WIDTH-1]};
      trial  = rem_sh - {1'b0, dv};
      if (!trial[WIDTH]) begin
         dr_n = trial[WIDTH-1:0];
         dq_n = {dq[WIDTH-2:0], 1'b1};
      end else begin
         dr_n = rem_sh[WIDTH-1:0];
         dq_n = {dq[WIDTH-2:0], 1'b0};
      end
   end

   assign div_by_zero = dbz;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL)
                  state_next = S_MUL;
`ifdef SEQ_ALU_DIV_EN
               else if (op == OP_DIV && b != '0)
                  state_next = S_DIV;
`endif
               else
                  state_next = S_DONE;
            end
         end
         S_MUL:   if (cnt == LAST) state_next = S_DONE;
`ifdef SEQ_ALU_DIV_EN
         S_DIV:   if (cnt == LAST) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
`endif
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         carry_out <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         bacc      <= '0;
         bq        <= '0;
         bq_m1     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         dq        <= '0;
         dr        <= '0;
         dv        <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dbz       <= 1'b0;
`endif
      end else begin
         busy <= (state_next != S_IDLE);
         done <= (state_next == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt   <= '0;
                  mcand <= a;
                  bacc  <= '0;
                  bq    <= b;
                  bq_m1 <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
                  dbz   <= 1'b0;
                  dq    <= a[WIDTH-1] ? '0 - a : a;
                  dv    <= b[WIDTH-1] ? '0 - b : b;
                  dr    <= '0;
                  neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                  neg_r <= a[WIDTH-1];
`endif
                  if (op == OP_MUL) begin
                     // result written when the last iteration retires
                  end
`ifdef SEQ_ALU_DIV_EN
                  else if (op == OP_DIV) begin
                     if (b == '0) begin
                        lo        <= '1;
                        hi        <= a;
                        carry_out <= 1'b0;
                        dbz       <= 1'b1;
                     end
                  end
`endif
                  else begin
                     lo        <= alu_res;
                     hi        <= '0;
                     carry_out <= alu_c;
                  end
               end
            end
            S_MUL: begin
               cnt   <= cnt + 1'b1;
               bacc  <= bacc_n;
               bq    <= bq_n;
               bq_m1 <= bq_m1_n;
               if (cnt == LAST) begin
                  hi        <= bacc_n[WIDTH-1:0];
                  lo        <= bq_n;
                  carry_out <= 1'b0;
               end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
               cnt <= cnt + 1'b1;
               dq  <= dq_n;
               dr  <= dr_n;
            end
            S_FIX: begin
               lo        <= neg_q ? '0 - dq : dq;
               hi        <= neg_r ? '0 - dr : dr;
               carry_out <= 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
